amiga_daug_dramctl: RTL

AMIGA_DAUG_DRAMCTL -- requirements
Module: amiga_daug_dramctl

---
 rtl/amiga_daug_pkg.sv | 40 ++++
 rtl/amiga_daug_refresh_timer.sv | 52 +++++
 rtl/amiga_daug_dramctl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/amiga_daug_pkg.sv
// Shared definitions for the Amiga daughterboard DRAM controller.
// Contents:
//   state_e    - controller state encoding
//   Cas*       - bit positions of each strobe within the 4-bit _CAS bus
//   cas_enable - active-high column-strobe mask for one CPU access
package amiga_daug_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRow,
        StCol,
        StHold,
        StPre,
        StRcas,
        StRras
    } state_e;

    localparam int unsigned CasB0Lo = 0;
    localparam int unsigned CasB1Lo = 1;
    localparam int unsigned CasB0Hi = 2;
    localparam int unsigned CasB1Hi = 3;

    // Returns which column strobes to assert (1 = assert) for the given bank
    // and active-low data strobes.
    function automatic logic [3:0] cas_enable(input logic bank,
                                              input logic uds_n,
                                              input logic lds_n);
        logic [3:0] en;
        en = 4'b0000;
        if (bank) begin
            en[CasB1Lo] = ~lds_n;
            en[CasB1Hi] = ~uds_n;
        end else begin
            en[CasB0Lo] = ~lds_n;
            en[CasB0Hi] = ~uds_n;
        end
        return en;
    endfunction

endpackage

// File: rtl/amiga_daug_refresh_timer.sv
// Refresh request generator.
// A free-running divider counts 0..REFRESH_DIV-1; every wrap adds one to a
// 2-bit pending count (saturating at 3). ACK removes one pending request.
// Ports:
//   CLK  - clock
//   _RST - asynchronous active-low reset
//   ACK  - one-cycle pulse when a refresh has completed
//   PEND - number of outstanding refresh requests (0..3)
module amiga_daug_refresh_timer #(
    parameter int unsigned REFRESH_DIV = 108
) (
    input  logic       CLK,
    input  logic       _RST,
    input  logic       ACK,
    output logic [1:0] PEND
);

    localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      pend_q, pend_d;
    logic            wrap;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            div_q  <= '0;
            pend_q <= 2'd0;
        end else begin
            div_q  <= div_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        wrap  = (div_q == DivLast);
        div_d = wrap ? '0 : div_q + DivW'(1);
    end

    // A wrap and an acknowledge in the same cycle cancel out.
    always_comb begin
        pend_d = pend_q;
        unique case ({wrap, ACK})
            2'b10:   pend_d = (pend_q == 2'd3) ? pend_q : pend_q + 2'd1;
            2'b01:   pend_d = (pend_q == 2'd0) ? pend_q : pend_q - 2'd1;
            default: pend_d = pend_q;
        endcase
    end

    assign PEND = pend_q;

endmodule

// File: rtl/amiga_daug_dramctl.sv
// DRAM controller for the Amiga daughterboard RAM (two banks, 68000 bus).
// Runs CPU read/write cycles (ROW -> COL -> HOLD -> PRE) and CAS-before-RAS
// refresh cycles (RCAS -> RRAS -> PRE); pending refreshes win arbitration.
// Ports:
//   CLK, _RST            - clock, asynchronous active-low reset
//   SEL, _AS, _UDS, _LDS - CPU decode and bus strobes
//   _PRW, A17            - read/write direction, bank select
//   _RAS, _CAS[3:0], _WE - DRAM strobes
//   MUX                  - row/column address mux select
//   _DTACK, _CDR, _CDW   - CPU acknowledge, read latch / write buffer enables
//   REF_ACT              - refresh cycle in progress
// All outputs decode from registered state, so reset drives them inactive at once.
module amiga_daug_dramctl #(
    parameter int unsigned REFRESH_DIV = 108,
    parameter int unsigned TRP         = 2,
    parameter int unsigned TRAS        = 3
) (
    input  logic       CLK,
    input  logic       _RST,
    input  logic       SEL,
    input  logic       _AS,
    input  logic       _UDS,
    input  logic       _LDS,
    input  logic       _PRW,
    input  logic       A17,
    output logic       _RAS,
    output logic [3:0] _CAS,
    output logic       _WE,
    output logic       MUX,
    output logic       _DTACK,
    output logic       _CDR,
    output logic       _CDW,
    output logic       REF_ACT
);

    import amiga_daug_pkg::*;

    localparam int unsigned CntMax = (TRP > TRAS) ? TRP : TRAS;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q;
    logic            bank_q;
    logic [1:0]      pend;
    logic            ack;
    logic            cpu_req;

    assign cpu_req = SEL & ~_AS;

    amiga_daug_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh_timer (
        .CLK  (CLK),
        ._RST (_RST),
        .ACK  (ack),
        .PEND (pend)
    );

    // State register, plus direction and bank captured on entry to ROW.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b1;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && state_d == StRow) begin
                we_q   <= _PRW;
                bank_q <= A17;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend != 2'd0) begin
                    state_d = StRcas;
                end else if (cpu_req) begin
                    state_d = StRow;
                end
            end
            StRow: state_d = StCol;
            StCol: state_d = StHold;
            StHold: begin
                if (_AS) begin
                    state_d = StPre;
                    cnt_d   = CntW'(TRP - 1);
                end
            end
            StPre: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRcas: begin
                state_d = StRras;
                cnt_d   = CntW'(TRAS - 1);
            end
            StRras: begin
                if (cnt_q == '0) begin
                    state_d = StPre;
                    cnt_d   = CntW'(TRP - 1);
                    ack     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode. _CAS follows the live data strobes so a late write
    // strobe still reaches the DRAM while the cycle is in COL/HOLD.
    always_comb begin
        _RAS    = 1'b1;
        _CAS    = 4'hF;
        _WE     = 1'b1;
        MUX     = 1'b0;
        _DTACK  = 1'b1;
        _CDR    = 1'b1;
        _CDW    = 1'b1;
        REF_ACT = 1'b0;
        unique case (state_q)
            StRow: begin
                _RAS = 1'b0;
                _WE  = we_q;
                _CDW = we_q;
            end
            StCol, StHold: begin
                _RAS   = 1'b0;
                MUX    = 1'b1;
                _CAS   = ~cas_enable(bank_q, _UDS, _LDS);
                _WE    = we_q;
                _CDW   = we_q;
                _CDR   = ~we_q;
                _DTACK = (state_q == StHold) ? 1'b0 : 1'b1;
            end
            StRcas: begin
                _CAS    = 4'h0;
                REF_ACT = 1'b1;
            end
            StRras: begin
                _RAS    = 1'b0;
                _CAS    = 4'h0;
                REF_ACT = 1'b1;
            end
            default: begin
                _RAS = 1'b1;
            end
        endcase
    end

endmodule
